// File: rtl/mux_row_sequencer.sv
// Row multiplexing sequencer for a scanned LED matrix driver.
// Orders preload, latch, display and blanking periods per row, with load handshake and underrun tracking.
module mux_row_sequencer #(
  parameter int unsigned NB_MUX_ROWS = 4,
  parameter int unsigned ON_WIDTH    = 16,
  parameter int unsigned DEAD_WIDTH  = 8
) (
  input  logic                           clk,
  input  logic                           nrst,
  input  logic                           enable,
  input  logic [ON_WIDTH-1:0]            on_cycles,
  input  logic [DEAD_WIDTH-1:0]          dead_cycles,
  input  logic                           load_done,
  output logic                           load_start,
  output logic [$clog2(NB_MUX_ROWS)-1:0] next_row,
  output logic                           latch,
  output logic                           blank,
  output logic [NB_MUX_ROWS-1:0]         row_en,
  output logic [$clog2(NB_MUX_ROWS)-1:0] cur_row,
  output logic                           frame_start,
  output logic                           underrun,
  input  logic                           clr_underrun
);

  localparam int unsigned ROW_W = $clog2(NB_MUX_ROWS);
  localparam int unsigned CNT_W = (ON_WIDTH > DEAD_WIDTH) ? ON_WIDTH : DEAD_WIDTH;
  localparam logic [ROW_W-1:0]       LAST_ROW = ROW_W'(NB_MUX_ROWS - 1);
  localparam logic [NB_MUX_ROWS-1:0] ROW_ONE  = NB_MUX_ROWS'(1);

  typedef enum logic [2:0] {
    IDLE,
    PRELOAD,
    SWITCH,
    DISPLAY,
    DEAD
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic              ready;
  logic              waiting;

  logic [CNT_W-1:0]  on_load_c;
  logic [CNT_W-1:0]  dead_load_c;
  logic [ROW_W-1:0]  row_inc_c;
  logic              cnt_zero_c;
  logic              enter_switch_c;

  // Counter reload values (zero treated as one cycle), row wrap and the SWITCH entry condition.
  always_comb begin
    on_load_c      = (on_cycles == '0)   ? '0 : CNT_W'(on_cycles - 1'b1);
    dead_load_c    = (dead_cycles == '0) ? '0 : CNT_W'(dead_cycles - 1'b1);
    row_inc_c      = (next_row == LAST_ROW) ? '0 : ROW_W'(next_row + 1'b1);
    cnt_zero_c     = (cnt == '0);
    enter_switch_c = 1'b0;
    case (state)
      PRELOAD: enter_switch_c = load_done;
      DEAD: begin
        if (waiting) begin
          enter_switch_c = load_done;
        end else begin
          // A load_done landing on the expiry cycle counts as ready.
          enter_switch_c = cnt_zero_c && (ready || load_done);
        end
      end
      default: enter_switch_c = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state       <= IDLE;
      cnt         <= '0;
      ready       <= 1'b0;
      waiting     <= 1'b0;
      load_start  <= 1'b0;
      next_row    <= '0;
      latch       <= 1'b0;
      blank       <= 1'b1;
      row_en      <= '0;
      cur_row     <= '0;
      frame_start <= 1'b0;
      underrun    <= 1'b0;
    end else begin
      // Pulses default low; a same-cycle underrun set below overrides the clear.
      latch       <= 1'b0;
      load_start  <= 1'b0;
      frame_start <= 1'b0;
      if (clr_underrun) begin
        underrun <= 1'b0;
      end

      if (!enable) begin
        state    <= IDLE;
        cnt      <= '0;
        ready    <= 1'b0;
        waiting  <= 1'b0;
        blank    <= 1'b1;
        row_en   <= '0;
        next_row <= '0;
        cur_row  <= '0;
      end else if (enter_switch_c) begin
        state       <= SWITCH;
        latch       <= 1'b1;
        load_start  <= 1'b1;
        frame_start <= (next_row == '0);
        cur_row     <= next_row;
        next_row    <= row_inc_c;
        cnt         <= on_load_c;
        ready       <= 1'b0;
        waiting     <= 1'b0;
        blank       <= 1'b1;
        row_en      <= '0;
      end else begin
        case (state)
          IDLE: begin
            blank      <= 1'b1;
            row_en     <= '0;
            load_start <= 1'b1;
            state      <= PRELOAD;
          end
          PRELOAD: begin
            state <= PRELOAD;
          end
          SWITCH: begin
            // load_done during SWITCH is deliberately not recorded.
            ready  <= 1'b0;
            blank  <= 1'b0;
            row_en <= ROW_ONE << cur_row;
            state  <= DISPLAY;
          end
          DISPLAY: begin
            if (load_done) begin
              ready <= 1'b1;
            end
            if (cnt_zero_c) begin
              blank  <= 1'b1;
              row_en <= '0;
              cnt    <= dead_load_c;
              state  <= DEAD;
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
          DEAD: begin
            if (load_done) begin
              ready <= 1'b1;
            end
            if (!waiting) begin
              if (cnt_zero_c) begin
                waiting  <= 1'b1;
                underrun <= 1'b1;
              end else begin
                cnt <= cnt - 1'b1;
              end
            end
          end
          default: begin
            state  <= IDLE;
            blank  <= 1'b1;
            row_en <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mux_row_sequencer.sv
// Bench for mux_row_sequencer: directed timing runs plus randomized traffic
// against a schedule-based reference model (row timing derived from switch timestamps).
module tb_mux_row_sequencer;

  localparam int unsigned NB  = 4;
  localparam int unsigned ONW = 16;
  localparam int unsigned DW  = 8;
  localparam int unsigned RW  = 2;

  logic           clk = 1'b0;
  logic           nrst;
  logic           enable;
  logic [ONW-1:0] on_cycles;
  logic [DW-1:0]  dead_cycles;
  logic           load_done;
  logic           load_start;
  logic [RW-1:0]  next_row;
  logic           latch;
  logic           blank;
  logic [NB-1:0]  row_en;
  logic [RW-1:0]  cur_row;
  logic           frame_start;
  logic           underrun;
  logic           clr_underrun;

  mux_row_sequencer #(
    .NB_MUX_ROWS(NB),
    .ON_WIDTH   (ONW),
    .DEAD_WIDTH (DW)
  ) dut (
    .clk         (clk),
    .nrst        (nrst),
    .enable      (enable),
    .on_cycles   (on_cycles),
    .dead_cycles (dead_cycles),
    .load_done   (load_done),
    .load_start  (load_start),
    .next_row    (next_row),
    .latch       (latch),
    .blank       (blank),
    .row_en      (row_en),
    .cur_row     (cur_row),
    .frame_start (frame_start),
    .underrun    (underrun),
    .clr_underrun(clr_underrun)
  );

  always #5 clk = ~clk;

  int n_pass;
  int n_total;
  int cyc;
  int due_q[$];

  // Reference model: mode 0 idle, 1 preload, 2 running; row timing is offset from the last switch cycle.
  int m_mode, m_pre, m_tsw, m_on, m_dead, m_row, m_nxt;
  bit m_rdy, m_und;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  function automatic int max1(input int v);
    return (v == 0) ? 1 : v;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_pre = 0; m_tsw = 0; m_on = 1; m_dead = 1;
    m_row = 0; m_nxt = 0; m_rdy = 1'b0; m_und = 1'b0;
  endtask

  task automatic go_switch();
    m_tsw  = cyc + 1;
    m_row  = m_nxt;
    m_nxt  = (m_nxt + 1) % NB;
    m_on   = max1(int'(on_cycles));
    m_rdy  = 1'b0;
    m_mode = 2;
  endtask

  // Advance the model across the coming clock edge using this cycle's inputs.
  task automatic model_step();
    int d;
    bit und_n;
    und_n = clr_underrun ? 1'b0 : m_und;
    if (!enable) begin
      m_mode = 0; m_nxt = 0; m_row = 0; m_rdy = 1'b0;
    end else if (m_mode == 0) begin
      m_mode = 1; m_pre = cyc + 1;
    end else if (m_mode == 1) begin
      if (load_done) go_switch();
    end else begin
      d = cyc - m_tsw;
      if (d == 0) m_rdy = 1'b0;
      else begin
        if (load_done) m_rdy = 1'b1;
        if (d == m_on) m_dead = max1(int'(dead_cycles));
        else if (d == m_on + m_dead) begin
          if (m_rdy) go_switch();
          else und_n = 1'b1;
        end else if (d > m_on + m_dead && load_done) go_switch();
      end
    end
    m_und = und_n;
  endtask

  task automatic model_check();
    int d;
    logic e_blank, e_latch, e_ls, e_fs;
    logic [NB-1:0] e_row_en;
    e_blank = 1'b1; e_latch = 1'b0; e_ls = 1'b0; e_fs = 1'b0; e_row_en = '0;
    if (m_mode == 1) e_ls = (cyc == m_pre);
    else if (m_mode == 2) begin
      d = cyc - m_tsw;
      if (d == 0) begin
        e_latch = 1'b1; e_ls = 1'b1; e_fs = (m_row == 0);
      end else if (d <= m_on) begin
        e_blank = 1'b0; e_row_en = NB'(1 << m_row);
      end
    end
    check("blank",       32'(blank),       32'(e_blank));
    check("row_en",      32'(row_en),      32'(e_row_en));
    check("latch",       32'(latch),       32'(e_latch));
    check("load_start",  32'(load_start),  32'(e_ls));
    check("frame_start", 32'(frame_start), 32'(e_fs));
    check("next_row",    32'(next_row),    32'(m_nxt));
    check("cur_row",     32'(cur_row),     32'(m_row));
    check("underrun",    32'(underrun),    32'(m_und));
  endtask

  task automatic step_cycle();
    model_step();
    @(posedge clk);
    #1;
    cyc++;
    model_check();
  endtask

  // Driver-side shift logic stand-in: answers each load_start after a delay.
  task automatic drive_load_done(input bit rnd);
    int dly;
    load_done = 1'b0;
    for (int i = due_q.size() - 1; i >= 0; i--) begin
      if (due_q[i] <= cyc) begin
        if (due_q[i] == cyc) load_done = 1'b1;
        due_q.delete(i);
      end
    end
    if (load_start) begin
      dly = 1;
      if (rnd) dly = ($urandom_range(0, 9) == 0) ? int'($urandom_range(6, 14)) : int'($urandom_range(1, 3));
      due_q.push_back(cyc + dly);
    end
  endtask

  // Enable rises at cycle k; with one-cycle load response the first latch lands at k+3.
  task automatic directed_run(input int on, input int dead, input int ncyc);
    int k, p, d, ph, r;
    on_cycles = ONW'(on); dead_cycles = DW'(dead); clr_underrun = 1'b0;
    enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      load_done = 1'b0;
      step_cycle();
      due_q.delete();
    end
    k = cyc;
    enable = 1'b1;
    p = 1 + max1(on) + max1(dead);
    for (int i = 0; i < ncyc; i++) begin
      drive_load_done(1'b0);
      step_cycle();
      if (cyc == k + 1) check("dir_preload_ls", 32'(load_start), 32'd1);
      d = cyc - (k + 3);
      if (d >= 0) begin
        ph = d % p;
        r  = (d / p) % NB;
        check("dir_latch", 32'(latch), 32'(ph == 0));
        check("dir_frame", 32'(frame_start), 32'(ph == 0 && r == 0));
        check("dir_row_en", 32'(row_en), (ph >= 1 && ph <= max1(on)) ? 32'(1 << r) : 32'd0);
      end
    end
  endtask

  initial begin
    int en_off;
    bit did_reset, saw_und;
    n_pass = 0; n_total = 0; cyc = 0;
    nrst = 1'b0; enable = 1'b0; load_done = 1'b0; clr_underrun = 1'b0;
    on_cycles = ONW'(3); dead_cycles = DW'(2);
    model_reset();
    @(posedge clk);
    #1;
    model_check();
    @(negedge clk);
    nrst = 1'b1;

    // Ends each run mid-display so the next run's enable drop hits DISPLAY.
    directed_run(3, 2, 29);
    directed_run(0, 0, 19);
    directed_run(3, 2, 10);

    en_off = 0; did_reset = 1'b0; saw_und = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (i > 1500 && !did_reset && m_mode == 2 && (cyc - m_tsw) >= 1 && (cyc - m_tsw) <= m_on) begin
        did_reset = 1'b1;
        #2 nrst = 1'b0;
        #1;
        check("async_blank", 32'(blank), 32'd1);
        check("async_row_en", 32'(row_en), 32'd0);
        model_reset();
        model_check();
        due_q.delete();
        @(negedge clk);
        nrst = 1'b1;
      end
      on_cycles    = ONW'($urandom_range(0, 4));
      dead_cycles  = DW'($urandom_range(0, 3));
      clr_underrun = ($urandom_range(0, 19) == 0);
      if (en_off > 0) begin
        en_off--;
        enable = 1'b0;
      end else begin
        enable = 1'b1;
        if ($urandom_range(0, 199) == 0) begin
          en_off = int'($urandom_range(0, 2));
          enable = 1'b0;
        end
      end
      drive_load_done(1'b1);
      load_done = load_done | ($urandom_range(0, 49) == 0);
      step_cycle();
      if (underrun) saw_und = 1'b1;
    end
    check("underrun_seen", 32'(saw_und), 32'd1);
    check("reset_pulsed", 32'(did_reset), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mux_row_sequencer.md
MUX_ROW_SEQUENCER -- requirements
Module: mux_row_sequencer

Interface
REQ-001 Parameter NB_MUX_ROWS, default 4, number of multiplexing rows scanned cyclically.
REQ-002 Parameter ON_WIDTH, default 16, width of on_cycles.
REQ-003 Parameter DEAD_WIDTH, default 8, width of dead_cycles.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 nrst  input  1  asynchronous, active-low reset.
REQ-006 enable  input  1  1 = scan rows; 0 = return to IDLE with LEDs off.
REQ-007 on_cycles  input  ON_WIDTH  row display time in clk cycles; 0 is treated as 1.
REQ-008 dead_cycles  input  DEAD_WIDTH  blanking time between rows; 0 is treated as 1.
REQ-009 load_done  input  1  single-cycle pulse from the driver shift logic: the data for next_row is loaded.
REQ-010 load_start  output  1  single-cycle pulse requesting a shift-out of the data for next_row.
REQ-011 next_row  output  $clog2(NB_MUX_ROWS)  index of the row whose data is being loaded.
REQ-012 latch  output  1  single-cycle driver latch pulse.
REQ-013 blank  output  1  1 = driver outputs disabled.
REQ-014 row_en  output  NB_MUX_ROWS  one-hot enable for the active row transistor, or all zero.
REQ-015 cur_row  output  $clog2(NB_MUX_ROWS)  index of the row currently displayed.
REQ-016 frame_start  output  1  single-cycle pulse coincident with the latch for row 0.
REQ-017 underrun  output  1  sticky flag: a DEAD period expired before load_done arrived.
REQ-018 clr_underrun  input  1  synchronous clear of underrun.

Function
REQ-019 The FSM SHALL have the states IDLE, PRELOAD, SWITCH, DISPLAY and DEAD; all outputs SHALL be registered or decoded from registered state only.
REQ-020 IDLE: blank=1, row_en=0, next_row=0; when enable=1, go to PRELOAD.
REQ-021 PRELOAD: load_start=1 on the first cycle only; stay until load_done=1, then go to SWITCH.
REQ-022 SWITCH lasts one cycle: latch=1; load_start=1; cur_row<=next_row; next_row<=next_row+1, wrapping NB_MUX_ROWS-1 to 0; on_cycles is sampled into the on-counter; the ready flag is cleared; next state DISPLAY.
REQ-023 frame_start SHALL be 1 in a SWITCH cycle exactly when the row being latched is 0.
REQ-024 DISPLAY: blank=0 and row_en=onehot(cur_row) for max(on_cycles,1) cycles; dead_cycles is then sampled, and the next state is DEAD.
REQ-025 DEAD: blank=1 and row_en=0 for max(dead_cycles,1) cycles; at expiry, go to SWITCH if ready=1, otherwise stay in DEAD until load_done, then go to SWITCH.
REQ-026 ready SHALL be set by a load_done pulse in any DISPLAY or DEAD cycle; a load_done pulse in the SWITCH cycle is ignored.
REQ-027 underrun SHALL be set in the first cycle after a DEAD expiry with ready=0; clr_underrun=1 clears it unless a set occurs in the same cycle (set wins).
REQ-028 row_en SHALL never have more than one bit set, and SHALL be all zero in every cycle in which blank=1.
REQ-029 With enable=0 sampled in any state, the next state SHALL be IDLE; next_row and cur_row SHALL go to 0, and ready SHALL be cleared; pending load_done pulses are ignored.
REQ-030 The steady-state row period with timely load_done SHALL be 1 + max(on,1) + max(dead,1) cycles.

Reset
REQ-031 With nrst=0: state=IDLE, blank=1, row_en=0, latch=0, load_start=0, frame_start=0, next_row=0, cur_row=0, ready=0, underrun=0, counters=0.
REQ-032 Reset assertion mid-DISPLAY SHALL force blank=1 and row_en=0 asynchronously, without waiting for a clock edge.

Verification
REQ-033 on=3, dead=2, load_done one cycle after each load_start, enable rises at cycle k -> load_start at k+1, SWITCH/latch/frame_start at k+3, row_en=0001 for k+4..k+6, blank for k+7..k+8, row_en=0010 from k+10.
REQ-034 Run for 4 rows -> row_en sequence 0001,0010,0100,1000,0001; frame_start only on the row-0 latches; period 6 cycles.
REQ-035 on=0, dead=0 -> DISPLAY and DEAD last 1 cycle each; period 3 cycles.
REQ-036 Withhold load_done until 5 cycles after DEAD expiry -> blank held with row_en=0 for the extra cycles, underrun=1, SWITCH on the cycle after load_done; clr_underrun clears the flag.
REQ-037 enable dropped mid-DISPLAY -> IDLE next cycle, row_en=0, blank=1; re-enable restarts at row 0 with a PRELOAD.
REQ-038 nrst pulsed mid-DISPLAY -> blank=1 and row_en=0 immediately; all outputs at reset values.
